// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcode fields,
// branch condition codes and datapath flag bit positions.
package instr_sequencer_pkg;

  localparam logic [2:0] ST_BOOT    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam logic [3:0]  OP_BCOND  = 4'hC;
  localparam logic [3:0]  EXT_CMP   = 4'hB;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_GT = 4'd4;
  localparam logic [3:0] CC_LE = 4'd5;
  localparam logic [3:0] CC_FS = 4'd6;
  localparam logic [3:0] CC_FC = 4'd7;
  localparam logic [3:0] CC_LO = 4'd8;
  localparam logic [3:0] CC_HI = 4'd9;
  localparam logic [3:0] CC_UC = 4'd14;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ext;
    logic [3:0] rs;
  } instr_t;

  // CMP only updates flags, so it must not pulse a register write enable.
  function automatic logic is_cmp(input instr_t ir);
    return (ir.op == 4'h0) && (ir.ext == EXT_CMP);
  endfunction

endpackage

// File: rtl/instr_sequencer_branch_cond.sv
// Branch condition evaluator: maps a 4-bit condition code and the latched
// flags to a taken decision.
module branch_cond
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = flags[FLAG_Z];
      CC_NE:   taken = !flags[FLAG_Z];
      CC_CS:   taken = flags[FLAG_C];
      CC_CC:   taken = !flags[FLAG_C];
      CC_GT:   taken = flags[FLAG_N];
      CC_LE:   taken = !flags[FLAG_N];
      CC_FS:   taken = flags[FLAG_F];
      CC_FC:   taken = !flags[FLAG_F];
      CC_LO:   taken = !flags[FLAG_L] && !flags[FLAG_Z];
      CC_HI:   taken = flags[FLAG_L];
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: fetches instruction words over a req/ack
// handshake, drives the datapath controls and resolves branches locally.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemReq,
  input  logic              MemAck,
  input  logic [15:0]       MemData,
  output logic [15:0]       Opcode,
  output logic [15:0]       RegEnable,
  output logic              Cin,
  input  logic [4:0]        Flags,
  output logic [4:0]        FlagReg,
  output logic              Halted
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  instr_t            ir;
  logic [4:0]        flag_reg;
  logic              taken;
  logic [ADDR_W-1:0] disp;

  assign disp = {{(ADDR_W-8){ir.ext[3]}}, ir.ext, ir.rs};

  branch_cond u_branch_cond (
    .cond  (ir.rd),
    .flags (flag_reg),
    .taken (taken)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      ir       <= '0;
      flag_reg <= '0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_FETCH;
        ST_FETCH: begin
          if (MemAck) begin
            ir    <= MemData;
            pc    <= pc + ADDR_W'(1);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (ir == HALT_WORD) begin
            state <= ST_HALT;
          end else if (ir.op == OP_BCOND) begin
            // pc already points past the branch; the -1 makes the target
            // relative to the branch word itself.
            if (taken) pc <= pc + disp - ADDR_W'(1);
            state <= ST_FETCH;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          flag_reg <= Flags;
          state    <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
    end
  end

  assign MemAddr   = pc;
  assign MemReq    = (state == ST_FETCH);
  assign Opcode    = ir;
  assign Cin       = flag_reg[FLAG_C];
  assign FlagReg   = flag_reg;
  assign Halted    = (state == ST_HALT);
  assign RegEnable = (state == ST_EXECUTE && !is_cmp(ir)) ? (16'h0001 << ir.rd) : 16'h0000;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: instruction-latency reference model
// compared every cycle, directed scenarios with literal expectations, random run.
module tb_instr_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] MemAddr;
  logic        MemReq;
  logic        MemAck = 1'b0;
  logic [15:0] MemData;
  logic [15:0] Opcode;
  logic [15:0] RegEnable;
  logic        Cin;
  logic [4:0]  Flags = 5'd0;
  logic [4:0]  FlagReg;
  logic        Halted;

  logic [15:0] mem [0:65535];
  logic [15:0] junk = 16'h0;
  int          ack_pct = 100;
  bit          flags_fix_en = 1'b1;
  logic [4:0]  flags_fix = 5'd0;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  instr_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .Clk(Clk), .Reset(Reset), .MemAddr(MemAddr), .MemReq(MemReq),
    .MemAck(MemAck), .MemData(MemData), .Opcode(Opcode), .RegEnable(RegEnable),
    .Cin(Cin), .Flags(Flags), .FlagReg(FlagReg), .Halted(Halted)
  );

  assign MemData = MemAck ? mem[MemAddr] : junk;

  always #5 Clk = ~Clk;

  // Memory and datapath stand-in: inputs change 2 time units after each edge.
  always @(posedge Clk) begin
    #2;
    MemAck = (int'($urandom_range(99)) < ack_pct);
    Flags  = flags_fix_en ? flags_fix : 5'($urandom);
    junk   = 16'($urandom);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: an instruction costs a fetch (plus waits) and then
  // 2 more cycles for ALU ops or 1 for branch/HALT; it retires on its last edge.
  logic [15:0] m_pc = 16'h0, m_ir = 16'h0;
  logic [4:0]  m_flags = 5'h0;
  bit          m_boot = 1'b1, m_fetching = 1'b0, m_halted = 1'b0;
  int          m_left = 0;

  function automatic bit is_alu(input logic [15:0] w);
    return (w != 16'hFFFF) && (w[15:12] != 4'hC);
  endfunction

  function automatic bit cond_true(input logic [3:0] c, input logic [4:0] f);
    case (c)
      4'd0:  return f[1];
      4'd1:  return !f[1];
      4'd2:  return f[4];
      4'd3:  return !f[4];
      4'd4:  return f[0];
      4'd5:  return !f[0];
      4'd6:  return f[2];
      4'd7:  return !f[2];
      4'd8:  return !f[3] && !f[1];
      4'd9:  return f[3];
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (!Reset) begin
      m_pc = 16'h0; m_ir = 16'h0; m_flags = 5'h0;
      m_boot = 1'b1; m_fetching = 1'b0; m_halted = 1'b0; m_left = 0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_fetching = 1'b1;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_fetching) begin
      if (MemAck) begin
        m_ir = mem[m_pc];
        m_pc = m_pc + 16'h1;
        m_fetching = 1'b0;
        m_left = is_alu(m_ir) ? 2 : 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_ir == 16'hFFFF) m_halted = 1'b1;
        else begin
          if (m_ir[15:12] == 4'hC) begin
            if (cond_true(m_ir[11:8], m_flags))
              m_pc = m_pc + {{8{m_ir[7]}}, m_ir[7:0]} - 16'h1;
          end else begin
            m_flags = Flags;
          end
          m_fetching = 1'b1;
        end
      end
    end
  end

  function automatic logic [63:0] exp_vec();
    logic [15:0] re;
    logic [15:0] one;
    one = 16'h0001;
    re = 16'h0;
    if (!m_boot && !m_fetching && !m_halted && m_left == 1 && is_alu(m_ir)
        && !(m_ir[15:12] == 4'h0 && m_ir[7:4] == 4'hB))
      re = one << m_ir[11:8];
    return {8'd0, m_fetching, m_pc, m_ir, re, m_flags[4], m_flags, m_halted};
  endfunction

  function automatic logic [63:0] act_vec();
    return {8'd0, MemReq, MemAddr, Opcode, RegEnable, Cin, FlagReg, Halted};
  endfunction

  always @(negedge Clk) if (chk_en) chk("cycle", act_vec(), exp_vec());

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("reset outputs", act_vec(), 64'd0);
    Reset = 1'b1;
  endtask

  task automatic wait_fetch(input logic [15:0] a, input string name);
    int n;
    n = 0;
    while (!(MemReq === 1'b1 && MemAddr === a) && n < 300) begin
      step();
      n++;
    end
    chk(name, {63'd0, (n < 300)}, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    logic [15:0] re_seen;
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // Zero-wait ALU op, then HALT.
    mem[0] = 16'h0152; mem[1] = 16'hFFFF;
    ack_pct = 100; flags_fix = 5'd0;
    do_reset();
    chk("boot req low", {63'd0, MemReq}, 64'd0);
    step();
    chk("first fetch", {47'd0, MemReq, MemAddr}, {47'd0, 1'b1, 16'h0000});
    pulses = 0; re_seen = 16'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (RegEnable != 16'h0) begin pulses++; re_seen = RegEnable; end
      if (i == 2) chk("pc after alu", {47'd0, MemReq, MemAddr}, {47'd0, 1'b1, 16'h0001});
    end
    chk("alu pulse count", 64'(pulses), 64'd1);
    chk("alu pulse value", {48'd0, re_seen}, {48'd0, 16'h0002});

    // Three wait cycles before the acknowledge.
    mem[0] = 16'h0345;
    ack_pct = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wait hold", {31'd0, MemReq, MemAddr, RegEnable}, {31'd0, 1'b1, 16'h0000, 16'h0000});
    end
    ack_pct = 100;
    step();
    chk("acked word", {47'd0, MemReq, Opcode}, {47'd0, 1'b0, 16'h0345});
    step();
    chk("wait exec", {48'd0, RegEnable}, {48'd0, 16'h0008});

    // CMP latches flags without a write, then a taken BEQ backwards.
    mem[0] = 16'h0100; mem[1] = 16'h0211; mem[2] = 16'h0322; mem[3] = 16'h0433;
    mem[4] = 16'h01B2; mem[5] = 16'hC0FE;
    flags_fix = 5'b00000;
    do_reset();
    wait_fetch(16'h0004, "reach cmp");
    step(); step();
    chk("cmp exec", {32'd0, Opcode, RegEnable}, {32'd0, 16'h01B2, 16'h0000});
    flags_fix = 5'b00010;
    step();
    chk("cmp flags", {43'd0, FlagReg, MemAddr}, {43'd0, 5'b00010, 16'h0005});
    step(); step();
    chk("beq target", {47'd0, MemReq, MemAddr}, {47'd0, 1'b1, 16'h0003});

    // Carry into ADDC, then a not-taken CC branch.
    mem[0] = 16'h0111; mem[1] = 16'h0723;
    for (int i = 2; i < 7; i++) mem[i] = 16'h0A00 + 16'(i);
    mem[7] = 16'hC3F0;
    flags_fix = 5'b10000;
    do_reset();
    wait_fetch(16'h0001, "reach addc");
    step(); step();
    chk("addc cin", {31'd0, Cin, Opcode, RegEnable}, {31'd0, 1'b1, 16'h0723, 16'h0080});
    wait_fetch(16'h0007, "reach bcc");
    step(); step();
    chk("bcc fallthrough", {47'd0, MemReq, MemAddr}, {47'd0, 1'b1, 16'h0008});

    // Wrap-around branches, then HALT held indefinitely.
    mem[0] = 16'hCEFF; mem[16'hFFFF] = 16'hCE02; mem[1] = 16'hFFFF;
    ack_pct = 50;
    do_reset();
    wait_fetch(16'hFFFF, "reach ffff");
    wait_fetch(16'h0001, "wrap target");
    n = 0;
    while (Halted !== 1'b1 && n < 300) begin step(); n++; end
    chk("halt reached", {63'd0, (n < 300)}, 64'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (i % 5 == 4)
        chk("halt hold", {30'd0, Halted, MemReq, RegEnable, MemAddr},
            {30'd0, 1'b1, 1'b0, 16'h0000, 16'h0002});
    end

    // Reset lands on the same edge as an acknowledge.
    mem[0] = 16'h0111; mem[1] = 16'h0152;
    ack_pct = 100; flags_fix = 5'b10001;
    do_reset();
    wait_fetch(16'h0001, "reach reset fetch");
    ack_pct = 0;
    step();
    chk("flags before reset", {59'd0, FlagReg}, {59'd0, 5'b10001});
    Reset = 1'b0; ack_pct = 100;
    step();
    chk("reset over ack", act_vec(), 64'd0);
    step();
    chk("reset hold", act_vec(), 64'd0);
    Reset = 1'b1;

    // Random programs, wait states, flags and occasional resets.
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(99) < 2) ? 16'hFFFF : 16'($urandom);
    flags_fix_en = 1'b0; ack_pct = 70;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step();
      Reset = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
    end
    Reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
